// File: rtl/fft_8p_pkg.sv
// rtl/fft_8p_pkg.sv - shared constants, state type and bit-reversal helper for the 8-point FFT
package fft_8p_pkg;

  localparam int N_POINTS = 8;
  localparam int LOG2N    = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_8p_s2p_frame.sv
// rtl/fft_8p_s2p_frame.sv - serial-to-parallel frame collector with double-buffered output
module fft_8p_s2p_frame
  import fft_8p_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int BIT_REV = 1,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic [DATA_W-1:0]     din_re,
  input  logic [DATA_W-1:0]     din_im,
  output logic [8*DATA_W-1:0]   dout_re,
  output logic [8*DATA_W-1:0]   dout_im,
  output logic                  frame_valid,
  output logic [2:0]            fill_idx,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_cnt
);

  state_t                r_state;
  state_t                w_next_state;
  logic [2:0]            r_fill_idx;
  logic [DATA_W-1:0]     r_shadow_re [N_POINTS];
  logic [DATA_W-1:0]     r_shadow_im [N_POINTS];
  logic [8*DATA_W-1:0]   r_dout_re;
  logic [8*DATA_W-1:0]   r_dout_im;
  logic [8*DATA_W-1:0]   w_frame_re;
  logic [8*DATA_W-1:0]   w_frame_im;
  logic                  r_frame_valid;
  logic [CNT_W-1:0]      r_frame_cnt;
  logic                  w_capture;
  logic                  w_last;
  logic [2:0]            w_slot;

  assign w_capture = en && !sync_clr;
  assign w_last    = w_capture && (r_fill_idx == 3'd7);
  assign w_slot    = (BIT_REV != 0) ? bitrev3(r_fill_idx) : r_fill_idx;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_next_state = S_FILL;
      S_FILL:  if (sync_clr || w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The completing sample bypasses the shadow so the whole frame lands in one edge.
  always_comb begin
    for (int s = 0; s < N_POINTS; s++) begin
      w_frame_re[s*DATA_W +: DATA_W] = r_shadow_re[s];
      w_frame_im[s*DATA_W +: DATA_W] = r_shadow_im[s];
    end
    w_frame_re[w_slot*DATA_W +: DATA_W] = din_re;
    w_frame_im[w_slot*DATA_W +: DATA_W] = din_im;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_fill_idx    <= 3'd0;
      r_dout_re     <= '0;
      r_dout_im     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= '0;
      for (int s = 0; s < N_POINTS; s++) begin
        r_shadow_re[s] <= '0;
        r_shadow_im[s] <= '0;
      end
    end else begin
      r_state       <= w_next_state;
      r_frame_valid <= w_last;
      if (sync_clr) begin
        r_fill_idx <= 3'd0;
      end else if (en) begin
        r_fill_idx          <= r_fill_idx + 3'd1;
        r_shadow_re[w_slot] <= din_re;
        r_shadow_im[w_slot] <= din_im;
      end
      if (w_last) begin
        r_dout_re   <= w_frame_re;
        r_dout_im   <= w_frame_im;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign dout_re     = r_dout_re;
  assign dout_im     = r_dout_im;
  assign frame_valid = r_frame_valid;
  assign fill_idx    = r_fill_idx;
  assign busy        = (r_fill_idx != 3'd0);
  assign frame_cnt   = r_frame_cnt;

endmodule
